// File: rtl/tcu_core_req_resp.sv
// Core-side responder for TCU core requests: polls CORE_REQ_INT, hands foreign-message
// requests to the core, then clears the interrupt and writes a RESP back to CORE_REQ.
module tcu_core_req_resp #(
  parameter int TCU_REG_DATA_SIZE = 64,
  parameter int TCU_REG_ADDR_SIZE = 32,
  parameter int TCU_REG_BSEL_SIZE = 8,
  parameter int TCU_EP_SIZE       = 16,
  parameter int TCU_VPEID_SIZE    = 16,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CORE_CFG_START = 32'h0000_3000,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CORE_REQ       = 32'h0000_3018,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CORE_REQ_INT   = TCU_REGADDR_CORE_CFG_START + 32'h8,
  parameter int POLL_INTERVAL     = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         enable_i,
  output logic                         resp_reg_en_o,
  output logic [TCU_REG_BSEL_SIZE-1:0] resp_reg_wben_o,
  output logic [TCU_REG_ADDR_SIZE-1:0] resp_reg_addr_o,
  output logic [TCU_REG_DATA_SIZE-1:0] resp_reg_wdata_o,
  input  logic [TCU_REG_DATA_SIZE-1:0] resp_reg_rdata_i,
  input  logic                         resp_reg_stall_i,
  output logic                         req_valid_o,
  output logic [TCU_EP_SIZE-1:0]       req_ep_o,
  output logic [TCU_VPEID_SIZE-1:0]    req_vpeid_o,
  input  logic                         req_ready_i,
  output logic                         resp_ready_o,
  input  logic                         resp_valid_i,
  output logic                         busy_o,
  output logic [7:0]                   stale_cnt_o
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_INT_RD     = 4'd1;
  localparam logic [3:0] ST_INT_CHK    = 4'd2;
  localparam logic [3:0] ST_REQ_RD     = 4'd3;
  localparam logic [3:0] ST_REQ_CHK    = 4'd4;
  localparam logic [3:0] ST_DELIVER    = 4'd5;
  localparam logic [3:0] ST_WAIT_RESP  = 4'd6;
  localparam logic [3:0] ST_CLEAR_INT  = 4'd7;
  localparam logic [3:0] ST_WRITE_RESP = 4'd8;

  localparam logic [1:0]  TYPE_RESP   = 2'd1;
  localparam logic [1:0]  TYPE_FORMSG = 2'd2;
  localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL - 1);

  logic [3:0]                state_r;
  logic [3:0]                state_nxt_s;
  logic [15:0]               poll_cnt_r;
  logic [7:0]                stale_cnt_r;
  logic [TCU_EP_SIZE-1:0]    ep_r;
  logic [TCU_VPEID_SIZE-1:0] vpeid_r;
  logic                      from_resp_r;
  logic [1:0]                rd_type_s;
  logic [TCU_EP_SIZE-1:0]    rd_ep_s;
  logic [TCU_VPEID_SIZE-1:0] rd_vpeid_s;
  logic                      rd_zero_s;

  // CORE_REQ value announcing that the core has handled the request
  function automatic logic [TCU_REG_DATA_SIZE-1:0] pack_resp(
    input logic [TCU_EP_SIZE-1:0]    ep,
    input logic [TCU_VPEID_SIZE-1:0] vpeid
  );
    logic [TCU_REG_DATA_SIZE-1:0] word;
    word = {TCU_REG_DATA_SIZE{1'b0}};
    word[1:0] = TYPE_RESP;
    word[TCU_EP_SIZE+1:2] = ep;
    word[TCU_REG_DATA_SIZE-1 -: TCU_VPEID_SIZE] = vpeid;
    return word;
  endfunction

  assign rd_type_s  = resp_reg_rdata_i[1:0];
  assign rd_ep_s    = resp_reg_rdata_i[TCU_EP_SIZE+1:2];
  assign rd_vpeid_s = resp_reg_rdata_i[TCU_REG_DATA_SIZE-1 -: TCU_VPEID_SIZE];
  assign rd_zero_s  = (resp_reg_rdata_i == {TCU_REG_DATA_SIZE{1'b0}});

  // Next-state decode; the *_CHK states consume rdata one cycle after the accepted read
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((poll_cnt_r == 16'd0) && enable_i) state_nxt_s = ST_INT_RD;
        else                                   state_nxt_s = ST_IDLE;
      end
      ST_INT_RD: begin
        if (!resp_reg_stall_i) state_nxt_s = ST_INT_CHK;
        else                   state_nxt_s = ST_INT_RD;
      end
      ST_INT_CHK: begin
        if (rd_zero_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_REQ_RD;
      end
      ST_REQ_RD: begin
        if (!resp_reg_stall_i) state_nxt_s = ST_REQ_CHK;
        else                   state_nxt_s = ST_REQ_RD;
      end
      ST_REQ_CHK: begin
        if (rd_type_s == TYPE_FORMSG)    state_nxt_s = ST_DELIVER;
        else if (rd_type_s == TYPE_RESP) state_nxt_s = ST_IDLE;
        else                             state_nxt_s = ST_CLEAR_INT;
      end
      ST_DELIVER: begin
        if (req_ready_i) state_nxt_s = ST_WAIT_RESP;
        else             state_nxt_s = ST_DELIVER;
      end
      ST_WAIT_RESP: begin
        if (resp_valid_i) state_nxt_s = ST_CLEAR_INT;
        else              state_nxt_s = ST_WAIT_RESP;
      end
      ST_CLEAR_INT: begin
        if (resp_reg_stall_i) state_nxt_s = ST_CLEAR_INT;
        else if (from_resp_r) state_nxt_s = ST_WRITE_RESP;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_WRITE_RESP: begin
        if (!resp_reg_stall_i) state_nxt_s = ST_IDLE;
        else                   state_nxt_s = ST_WRITE_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= ST_IDLE;
    else            state_r <= state_nxt_s;
  end

  // Poll interval counter: reloaded whenever IDLE is re-entered
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      poll_cnt_r <= POLL_RELOAD;
    end else if ((state_r != ST_IDLE) && (state_nxt_s == ST_IDLE)) begin
      poll_cnt_r <= POLL_RELOAD;
    end else if ((state_r == ST_IDLE) && (poll_cnt_r != 16'd0)) begin
      poll_cnt_r <= poll_cnt_r - 16'd1;
    end else begin
      poll_cnt_r <= poll_cnt_r;
    end
  end

  // Request capture and the flag that routes CLEAR_INT on to WRITE_RESP
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ep_r        <= {TCU_EP_SIZE{1'b0}};
      vpeid_r     <= {TCU_VPEID_SIZE{1'b0}};
      from_resp_r <= 1'b0;
    end else if (state_r == ST_REQ_CHK) begin
      from_resp_r <= 1'b0;
      if (rd_type_s == TYPE_FORMSG) begin
        ep_r    <= rd_ep_s;
        vpeid_r <= rd_vpeid_s;
      end
    end else if ((state_r == ST_WAIT_RESP) && resp_valid_i) begin
      from_resp_r <= 1'b1;
    end
  end

  // Stale-request counter, saturating
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stale_cnt_r <= 8'd0;
    end else if ((state_r == ST_REQ_CHK) && (rd_type_s != TYPE_FORMSG) &&
                 (rd_type_s != TYPE_RESP) && (stale_cnt_r != 8'hFF)) begin
      stale_cnt_r <= stale_cnt_r + 8'd1;
    end
  end

  // Register-port drive, decoded from state and the captured request
  always_comb begin
    resp_reg_en_o    = 1'b0;
    resp_reg_wben_o  = {TCU_REG_BSEL_SIZE{1'b0}};
    resp_reg_addr_o  = {TCU_REG_ADDR_SIZE{1'b0}};
    resp_reg_wdata_o = {TCU_REG_DATA_SIZE{1'b0}};
    case (state_r)
      ST_INT_RD: begin
        resp_reg_en_o   = 1'b1;
        resp_reg_addr_o = TCU_REGADDR_CORE_REQ_INT;
      end
      ST_REQ_RD: begin
        resp_reg_en_o   = 1'b1;
        resp_reg_addr_o = TCU_REGADDR_CORE_REQ;
      end
      ST_CLEAR_INT: begin
        resp_reg_en_o   = 1'b1;
        resp_reg_wben_o = {TCU_REG_BSEL_SIZE{1'b1}};
        resp_reg_addr_o = TCU_REGADDR_CORE_REQ_INT;
      end
      ST_WRITE_RESP: begin
        resp_reg_en_o    = 1'b1;
        resp_reg_wben_o  = {TCU_REG_BSEL_SIZE{1'b1}};
        resp_reg_addr_o  = TCU_REGADDR_CORE_REQ;
        resp_reg_wdata_o = pack_resp(ep_r, vpeid_r);
      end
      default: begin
        resp_reg_en_o = 1'b0;
      end
    endcase
  end

  assign req_valid_o  = (state_r == ST_DELIVER);
  assign resp_ready_o = (state_r == ST_WAIT_RESP);
  assign busy_o       = (state_r != ST_IDLE);
  assign req_ep_o     = ep_r;
  assign req_vpeid_o  = vpeid_r;
  assign stale_cnt_o  = stale_cnt_r;

endmodule
